// File: rtl/basilisk_divide_iterate_pkg.sv
// Shared types for the basilisk divide iterate stage: operand/result payloads, FSM states and the
// single restoring-division step used by the RUN loop.
package basilisk_divide_iterate_pkg;

  localparam int BASILISK_DIVIDE_QUOTIENT_WIDTH = 26;
  localparam int BASILISK_DIVIDE_MANT_WIDTH     = 24;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic div_by_zero;
  } basilisk_divide_flags_t;

  typedef struct packed {
    logic                   sign;
    logic [9:0]             exponent;
    logic [23:0]            mant_a;
    logic [23:0]            mant_b;
    basilisk_divide_flags_t flags;
    logic [4:0]             dest_reg;
    logic [2:0]             round_mode;
  } basilisk_divide_command_t;

  typedef struct packed {
    logic                   sign;
    logic [9:0]             exponent;
    logic [25:0]            quotient;
    logic                   sticky;
    basilisk_divide_flags_t flags;
    logic [4:0]             dest_reg;
    logic [2:0]             round_mode;
  } basilisk_divide_result_t;

  typedef struct packed {
    logic        q_bit;
    logic [25:0] rem;
  } fpu_div_step_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } basilisk_divide_state_t;

  // One restoring step: compare, conditionally subtract, then shift the partial remainder.
  function automatic fpu_div_step_t fpu_float_div_step(input logic [25:0] rem, input logic [23:0] div);
    fpu_div_step_t r;
    logic [25:0]   div_ext;
    div_ext = {2'b00, div};
    if (rem >= div_ext) begin
      r.q_bit = 1'b1;
      r.rem   = (rem - div_ext) << 1;
    end else begin
      r.q_bit = 1'b0;
      r.rem   = rem << 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/basilisk_divide_iterate_flow_stage.sv
// Output flow stage: MODE 0 is a wire-through, any other MODE is a full-throughput register slice.
// Latency 0 or 1 cycle; upstream ready follows downstream ready, or register-empty in register mode.
// Payload is held stable while dst_vld && !dst_rdy.
module basilisk_divide_iterate_flow_stage #(
  parameter int WIDTH = 8,
  parameter int MODE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_vld,
  output logic             src_rdy,
  input  logic [WIDTH-1:0] src_dat,
  output logic             dst_vld,
  input  logic             dst_rdy,
  output logic [WIDTH-1:0] dst_dat
);

  generate
    if (MODE == 0) begin : g_pass
      assign dst_vld = src_vld;
      assign dst_dat = src_dat;
      assign src_rdy = dst_rdy;
    end else begin : g_reg
      logic             vld_q;
      logic [WIDTH-1:0] dat_q;

      assign src_rdy = !vld_q || dst_rdy;
      assign dst_vld = vld_q;
      assign dst_dat = dat_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q <= 1'b0;
          dat_q <= '0;
        end else if (src_rdy) begin
          vld_q <= src_vld;
          if (src_vld) dat_q <= src_dat;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/basilisk_divide_iterate.sv
// Radix-2 restoring mantissa divider producing a raw 26-bit quotient plus sticky, one operation in flight.
// Latency 1 + 26/BITS_PER_CYCLE + 1 cycles (+1 with output register); specials go straight to DONE.
// Stalls in DONE under backpressure; BASILISK_DIVIDE_EARLY_EXIT_EN ends RUN once the remainder is zero.
module basilisk_divide_iterate
  import basilisk_divide_iterate_pkg::*;
#(
  parameter int BITS_PER_CYCLE       = 1,
  parameter int OUTPUT_REGISTER_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     divide_exponent_command_vld,
  output logic                     divide_exponent_command_rdy,
  input  basilisk_divide_command_t divide_exponent_command_dat,
  output logic                     divide_operation_command_vld,
  input  logic                     divide_operation_command_rdy,
  output basilisk_divide_result_t  divide_operation_command_dat
);

  localparam int         QW       = BASILISK_DIVIDE_QUOTIENT_WIDTH;
  localparam logic [4:0] CNT_STEP = 5'(BITS_PER_CYCLE);
  localparam logic [4:0] CNT_LAST = 5'(QW);

  basilisk_divide_state_t state;
  logic [QW-1:0]          rem;
  logic [QW-1:0]          quot;
  logic [23:0]            div;
  logic [4:0]             cnt;
  logic [4:0]             cnt_next;
  logic [QW-1:0]          step_rem;
  logic [QW-1:0]          step_quot;
  fpu_div_step_t          step;

  logic                   sign;
  logic [9:0]             exponent;
  basilisk_divide_flags_t flags;
  logic [4:0]             dest_reg;
  logic [2:0]             round_mode;

  logic                    cmd_rdy;
  logic                    res_vld;
  logic                    res_rdy;
  basilisk_divide_result_t res_dat;
  logic                    handoff;

  assign divide_exponent_command_rdy = cmd_rdy;
  assign handoff  = divide_operation_command_vld && divide_operation_command_rdy;
  assign cnt_next = cnt + CNT_STEP;

  // BITS_PER_CYCLE restoring steps chained combinationally.
  always_comb begin
    step      = '0;
    step_rem  = rem;
    step_quot = quot;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      step      = fpu_float_div_step(step_rem, div);
      step_rem  = step.rem;
      step_quot = {step_quot[QW-2:0], step.q_bit};
    end
  end

  always_comb begin
    res_dat            = '0;
    res_dat.sign       = sign;
    res_dat.exponent   = exponent;
    res_dat.quotient   = quot;
    res_dat.sticky     = |rem;
    res_dat.flags      = flags;
    res_dat.dest_reg   = dest_reg;
    res_dat.round_mode = round_mode;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rem        <= '0;
      quot       <= '0;
      div        <= '0;
      cnt        <= '0;
      sign       <= 1'b0;
      exponent   <= '0;
      flags      <= '0;
      dest_reg   <= '0;
      round_mode <= '0;
      cmd_rdy    <= 1'b0;
      res_vld    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_rdy && divide_exponent_command_vld) begin
            cmd_rdy    <= 1'b0;
            sign       <= divide_exponent_command_dat.sign;
            exponent   <= divide_exponent_command_dat.exponent;
            flags      <= divide_exponent_command_dat.flags;
            dest_reg   <= divide_exponent_command_dat.dest_reg;
            round_mode <= divide_exponent_command_dat.round_mode;
            div        <= divide_exponent_command_dat.mant_b;
            quot       <= '0;
            cnt        <= '0;
            if (divide_exponent_command_dat.flags != '0) begin
              rem     <= '0;
              res_vld <= 1'b1;
              state   <= DONE;
            end else begin
              rem   <= {2'b00, divide_exponent_command_dat.mant_a};
              state <= RUN;
            end
          end else begin
            cmd_rdy <= 1'b1;
          end
        end
        RUN: begin
          rem  <= step_rem;
          quot <= step_quot;
          cnt  <= cnt_next;
          if (cnt_next == CNT_LAST) begin
            res_vld <= 1'b1;
            state   <= DONE;
          end
`ifdef BASILISK_DIVIDE_EARLY_EXIT_EN
          else if (step_rem == '0) begin
            // Remaining quotient bits would all be zero; place the retired bits at the top.
            quot    <= step_quot << (CNT_LAST - cnt_next);
            res_vld <= 1'b1;
            state   <= DONE;
          end
`endif
        end
        DONE: begin
          if (res_vld && res_rdy) res_vld <= 1'b0;
          // Leave only once the result has left the output stage, keeping one operation in flight.
          if (handoff) begin
            res_vld <= 1'b0;
            cmd_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  basilisk_divide_iterate_flow_stage #(
    .WIDTH($bits(basilisk_divide_result_t)),
    .MODE (OUTPUT_REGISTER_MODE)
  ) u_out_stage (
    .clk     (clk),
    .rst     (rst),
    .src_vld (res_vld),
    .src_rdy (res_rdy),
    .src_dat (res_dat),
    .dst_vld (divide_operation_command_vld),
    .dst_rdy (divide_operation_command_rdy),
    .dst_dat (divide_operation_command_dat)
  );

endmodule

// File: tb/tb_basilisk_divide_iterate.sv
// Bench for basilisk_divide_iterate: directed cases plus randomized operands against an arithmetic model.
module tb_basilisk_divide_iterate;
  import basilisk_divide_iterate_pkg::*;

  localparam int BPC        = 1;
  localparam int MODE       = 1;
  localparam int BPC2       = 2;
  localparam int MODE2      = 0;
  localparam int NUM_RANDOM = 500;
  localparam int LIMIT      = 60000;

  logic clk = 1'b0;
  logic rst;
  logic cmd_vld, cmd_rdy, res_vld, res_rdy;
  basilisk_divide_command_t cmd_dat;
  basilisk_divide_result_t  res_dat;
  logic cmd2_vld, cmd2_rdy, res2_vld, res2_rdy;
  basilisk_divide_command_t cmd2_dat;
  basilisk_divide_result_t  res2_dat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  basilisk_divide_iterate #(.BITS_PER_CYCLE(BPC), .OUTPUT_REGISTER_MODE(MODE)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .divide_exponent_command_vld  (cmd_vld),
    .divide_exponent_command_rdy  (cmd_rdy),
    .divide_exponent_command_dat  (cmd_dat),
    .divide_operation_command_vld (res_vld),
    .divide_operation_command_rdy (res_rdy),
    .divide_operation_command_dat (res_dat)
  );

  basilisk_divide_iterate #(.BITS_PER_CYCLE(BPC2), .OUTPUT_REGISTER_MODE(MODE2)) dut2 (
    .clk                          (clk),
    .rst                          (rst),
    .divide_exponent_command_vld  (cmd2_vld),
    .divide_exponent_command_rdy  (cmd2_rdy),
    .divide_exponent_command_dat  (cmd2_dat),
    .divide_operation_command_vld (res2_vld),
    .divide_operation_command_rdy (res2_rdy),
    .divide_operation_command_dat (res2_dat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: quotient = floor(a * 2^25 / b), sticky = nonzero remainder; specials give zero.
  function automatic basilisk_divide_result_t model(input basilisk_divide_command_t c);
    basilisk_divide_result_t r;
    longint unsigned num, den;
    r            = '0;
    r.sign       = c.sign;
    r.exponent   = c.exponent;
    r.flags      = c.flags;
    r.dest_reg   = c.dest_reg;
    r.round_mode = c.round_mode;
    if (c.flags == '0) begin
      num        = {40'b0, c.mant_a} << 25;
      den        = {40'b0, c.mant_b};
      r.quotient = 26'(num / den);
      r.sticky   = (num % den) != 0;
    end
    return r;
  endfunction

  // Clock edges from the accept edge until output valid is first seen.
  function automatic int exp_lat(input basilisk_divide_command_t c, input int bpc, input int mode);
    int rc;
    bit found;
    rc    = 26 / bpc;
    found = 1'b0;
    if (c.flags != '0) rc = 0;
`ifdef BASILISK_DIVIDE_EARLY_EXIT_EN
    else begin
      for (int k = 1; k <= 26 / bpc; k++) begin
        if (!found && ((({40'b0, c.mant_a}) << (k * bpc - 1)) % {40'b0, c.mant_b}) == 0) begin
          rc    = k;
          found = 1'b1;
        end
      end
    end
`endif
    return rc + ((mode != 0) ? 1 : 0) + (found ? 0 : 0);
  endfunction

  function automatic basilisk_divide_command_t mk_cmd(input logic [23:0] a, input logic [23:0] b,
                                                      input basilisk_divide_flags_t f);
    basilisk_divide_command_t c;
    c.sign       = 1'($urandom);
    c.exponent   = 10'($urandom);
    c.mant_a     = a;
    c.mant_b     = b;
    c.flags      = f;
    c.dest_reg   = 5'($urandom);
    c.round_mode = 3'($urandom);
    return c;
  endfunction

  task automatic run_op(input basilisk_divide_command_t c, output basilisk_divide_result_t r,
                        output int lat, output bit got);
    int guard;
    got = 1'b0; lat = 0; r = '0; guard = 0;
    cmd_dat = c; cmd_vld = 1'b1; res_rdy = 1'b1;
    while (!cmd_rdy && guard < 100) begin tick(); guard++; end
    if (!cmd_rdy) begin cmd_vld = 1'b0; return; end
    tick();
    cmd_vld = 1'b0;
    while (!res_vld && lat < 200) begin tick(); lat++; end
    if (res_vld) begin r = res_dat; got = 1'b1; tick(); end
  endtask

  task automatic run_op2(input basilisk_divide_command_t c, output basilisk_divide_result_t r,
                         output int lat, output bit got);
    int guard;
    got = 1'b0; lat = 0; r = '0; guard = 0;
    cmd2_dat = c; cmd2_vld = 1'b1; res2_rdy = 1'b1;
    while (!cmd2_rdy && guard < 100) begin tick(); guard++; end
    if (!cmd2_rdy) begin cmd2_vld = 1'b0; return; end
    tick();
    cmd2_vld = 1'b0;
    while (!res2_vld && lat < 200) begin tick(); lat++; end
    if (res2_vld) begin r = res2_dat; got = 1'b1; tick(); end
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_vld = 1'b0; res_rdy = 1'b0; cmd_dat = '0;
    cmd2_vld = 1'b0; res2_rdy = 1'b1; cmd2_dat = '0;
    repeat (3) tick();
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL reset_res_vld: got %b expected 0", res_vld); end
    checks++; if (res2_vld !== 1'b0) begin errors++; $display("FAIL reset_res2_vld: got %b expected 0", res2_vld); end
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL idle_cmd_rdy: got %b expected 1", cmd_rdy); end
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL idle_res_vld: got %b expected 0", res_vld); end
  endtask

  task automatic test_six_by_two();
    basilisk_divide_command_t c;
    basilisk_divide_result_t r;
    int lat; bit got;
    c = mk_cmd(24'hC00000, 24'h800000, '0);
    run_op(c, r, lat, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL six_by_two_done: got %b expected 1", got); end
    checks++; if (r.quotient !== 26'h3000000) begin errors++; $display("FAIL six_by_two_quot: got %h expected 3000000", r.quotient); end
    checks++; if (r.sticky !== 1'b0) begin errors++; $display("FAIL six_by_two_sticky: got %b expected 0", r.sticky); end
    checks++; if (r !== model(c)) begin errors++; $display("FAIL six_by_two_fields: got %h expected %h", r, model(c)); end
    checks++; if (lat !== exp_lat(c, BPC, MODE)) begin errors++; $display("FAIL six_by_two_latency: got %0d expected %0d", lat, exp_lat(c, BPC, MODE)); end
  endtask

  task automatic test_one_third();
    basilisk_divide_command_t c;
    basilisk_divide_result_t r;
    int lat; bit got;
    c = mk_cmd(24'h800000, 24'hC00000, '0);
    run_op(c, r, lat, got);
    checks++; if (r.quotient !== 26'h1555555) begin errors++; $display("FAIL one_third_quot: got %h expected 1555555", r.quotient); end
    checks++; if (r.sticky !== 1'b1) begin errors++; $display("FAIL one_third_sticky: got %b expected 1", r.sticky); end
    checks++; if (r.quotient[25] !== 1'b0) begin errors++; $display("FAIL one_third_int_bit: got %b expected 0", r.quotient[25]); end
    checks++; if (lat !== exp_lat(c, BPC, MODE)) begin errors++; $display("FAIL one_third_latency: got %0d expected %0d", lat, exp_lat(c, BPC, MODE)); end
  endtask

  task automatic test_bits_per_cycle_2();
    basilisk_divide_command_t c;
    basilisk_divide_result_t r;
    int lat; bit got;
    c = mk_cmd(24'h800000, 24'hC00000, '0);
    run_op2(c, r, lat, got);
    checks++; if (r.quotient !== 26'h1555555 || r.sticky !== 1'b1) begin errors++; $display("FAIL bpc2_one_third: got %h/%b expected 1555555/1", r.quotient, r.sticky); end
    checks++; if (lat !== 13) begin errors++; $display("FAIL bpc2_latency: got %0d expected 13", lat); end
    c = mk_cmd(24'hC00000, 24'h800000, '0);
    run_op2(c, r, lat, got);
    checks++; if (r !== model(c)) begin errors++; $display("FAIL bpc2_six_by_two: got %h expected %h", r, model(c)); end
    checks++; if (lat !== exp_lat(c, BPC2, MODE2)) begin errors++; $display("FAIL bpc2_six_latency: got %0d expected %0d", lat, exp_lat(c, BPC2, MODE2)); end
  endtask

  task automatic test_divide_by_zero();
    basilisk_divide_command_t c;
    basilisk_divide_result_t r;
    basilisk_divide_flags_t f;
    int lat; bit got;
    f = '0; f.div_by_zero = 1'b1;
    c = mk_cmd(24'h800000, 24'h000000, f);
    run_op(c, r, lat, got);
    checks++; if (r.quotient !== 26'h0 || r.sticky !== 1'b0) begin errors++; $display("FAIL dz_result: got %h/%b expected 0/0", r.quotient, r.sticky); end
    checks++; if (r.flags !== f) begin errors++; $display("FAIL dz_flags: got %b expected %b", r.flags, f); end
    checks++; if (r !== model(c)) begin errors++; $display("FAIL dz_fields: got %h expected %h", r, model(c)); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_backpressure();
    basilisk_divide_command_t c, c2;
    basilisk_divide_result_t first, r;
    int guard;
    c  = mk_cmd(24'hC00000, 24'h800000, '0);
    c2 = mk_cmd(24'h800000, 24'hC00000, '0);
    res_rdy = 1'b0; cmd_dat = c; cmd_vld = 1'b1; guard = 0;
    while (!cmd_rdy && guard < 100) begin tick(); guard++; end
    tick();
    cmd_dat = c2;
    guard = 0;
    while (!res_vld && guard < 200) begin tick(); guard++; end
    first = res_dat;
    checks++; if (first !== model(c)) begin errors++; $display("FAIL bp_first: got %h expected %h", first, model(c)); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (res_vld !== 1'b1 || res_dat !== first || cmd_rdy !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: vld=%b rdy=%b dat=%h expected vld=1 rdy=0 dat=%h", i, res_vld, cmd_rdy, res_dat, first);
      end
    end
    res_rdy = 1'b1;
    tick();
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL bp_single_transfer: vld got %b expected 0", res_vld); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", cmd_rdy); end
    tick();
    cmd_vld = 1'b0;
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL bp_next_accept: rdy got %b expected 0", cmd_rdy); end
    guard = 0;
    while (!res_vld && guard < 200) begin tick(); guard++; end
    r = res_dat;
    checks++; if (r !== model(c2)) begin errors++; $display("FAIL bp_next_result: got %h expected %h", r, model(c2)); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    basilisk_divide_command_t c;
    basilisk_divide_result_t r;
    int lat, guard, stray; bit got;
    c = mk_cmd(24'h800000, 24'hC00000, '0);
    res_rdy = 1'b1; cmd_dat = c; cmd_vld = 1'b1; guard = 0;
    while (!cmd_rdy && guard < 100) begin tick(); guard++; end
    tick();
    cmd_vld = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    #1;
    checks++; if (res_vld !== 1'b0 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL mid_run_reset: vld=%b rdy=%b expected 0/0", res_vld, cmd_rdy); end
    repeat (2) tick();
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (res_vld) stray++; end
    checks++; if (stray !== 0) begin errors++; $display("FAIL mid_run_stale: got %0d valid cycles expected 0", stray); end
    c = mk_cmd(24'hC00000, 24'h800000, '0);
    run_op(c, r, lat, got);
    checks++; if (r.quotient !== 26'h3000000 || r.sticky !== 1'b0) begin errors++; $display("FAIL mid_run_after: got %h/%b expected 3000000/0", r.quotient, r.sticky); end
    checks++; if (lat !== exp_lat(c, BPC, MODE)) begin errors++; $display("FAIL mid_run_latency: got %0d expected %0d", lat, exp_lat(c, BPC, MODE)); end
  endtask

  task automatic test_random();
    basilisk_divide_result_t exp_q[$];
    int consumed, cyc;
    consumed = 0; cyc = 0;
    fork
      begin
        basilisk_divide_command_t c;
        for (int n = 0; n < NUM_RANDOM && cyc < LIMIT; n++) begin
          c = mk_cmd({1'b1, 23'($urandom)}, {1'b1, 23'($urandom)}, '0);
          cmd_dat = c; cmd_vld = 1'b1;
          while (!cmd_rdy && cyc < LIMIT) tick();
          if (cmd_rdy) exp_q.push_back(model(c));
          tick();
          cmd_vld = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        basilisk_divide_result_t e;
        while (consumed < NUM_RANDOM && cyc < LIMIT) begin
          res_rdy = 1'($urandom_range(0, 1));
          if (res_vld && res_rdy) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (res_dat !== e) begin errors++; $display("FAIL random[%0d]: got %h expected %h", consumed, res_dat, e); end
            consumed++;
          end
          tick();
        end
      end
      begin
        while (consumed < NUM_RANDOM && cyc < LIMIT) begin tick(); cyc++; end
      end
    join
    cmd_vld = 1'b0; res_rdy = 1'b1;
    checks++; if (consumed !== NUM_RANDOM) begin errors++; $display("FAIL random_count: got %0d expected %0d", consumed, NUM_RANDOM); end
  endtask

  initial begin
    test_reset();
    test_six_by_two();
    test_one_third();
    test_bits_per_cycle_2();
    test_divide_by_zero();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/basilisk_divide_iterate.md
Name: basilisk_divide_iterate

Overview:
- Iterative mantissa divider stage of the basilisk FP divide pipeline.
- Consumes decoded operands (sign, exponent difference, 24-bit mantissas with hidden bit, special-case flags).
- Produces a raw 26-bit quotient plus a sticky bit as basilisk_divide_result_t for the downstream divide-normalize stage.
- Radix-2 restoring division, multi-cycle, one operation in flight.

Parameters:
- BITS_PER_CYCLE, 1: quotient bits retired per cycle; legal values are 1 and 2.
- OUTPUT_REGISTER_MODE, 1: mode of the std_flow_stage on the output stream.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- divide_exponent_command  in (std_stream_intf)  valid/ready/basilisk_divide_command_t  decoded operands.
- divide_operation_command  out (std_stream_intf)  valid/ready/basilisk_divide_result_t  raw quotient to normalize.

Behaviour:
- Reset (rst low, asynchronous): FSM to IDLE; quotient, remainder and counter cleared; output valid 0; input ready 0 while in reset.
- FSM states:
  - IDLE: ready=1. On valid&ready, latch the payload.
    - Any special flag set (NaN, inf, zero, divide-by-zero) -> DONE with quotient 0, sticky 0, flags passed through.
    - Otherwise rem <= {2'b0, mant_a}, div <= mant_b, cnt <= 0 -> RUN.
  - RUN: ready=0. Each step: if rem >= {2'b0, div} then q bit = 1 and rem -= div, else q bit = 0; then rem <<= 1, q <<= 1 | bit.
    - BITS_PER_CYCLE steps are chained combinationally per cycle; cnt += BITS_PER_CYCLE.
    - When cnt reaches 26 -> DONE.
  - DONE: drive output valid with the latched result. On output ready -> IDLE.
- Widths:
  - Remainder 26 bits; quotient 26 bits.
  - q[25] is the integer bit. Quotient value lies in (0.5, 2).
  - q[25]=0 is legal; normalization and the exponent adjust are the downstream stage's job.
  - sticky = |rem after the final step.
  - Exponent, sign, dest register and rounding mode pass through unmodified.
- Latency, non-special: 1 cycle accept + 26/BITS_PER_CYCLE RUN cycles + 1 DONE cycle + output stage register (if OUTPUT_REGISTER_MODE ≠ 0).
- Latency, special: accept -> DONE next cycle.
- Handshake: input ready only in IDLE. No new accept in the same cycle DONE hands off; IDLE is re-entered first. Output payload stable while valid && !ready.
- Backpressure in DONE holds state indefinitely; nothing is dropped.
- Reset mid-RUN: operation discarded, no output produced.

Optional Feature:
- Macro: BASILISK_DIVIDE_EARLY_EXIT_EN.
- Defined:
  - In RUN, if rem == 0 after a cycle's steps, jump to DONE.
  - Remaining quotient bits are zero-filled (q shifted left by 26-cnt); sticky = 0.
  - Exact results, e.g. 1.0/1.0, finish after the first RUN cycle.
- Undefined: always the full 26/BITS_PER_CYCLE RUN cycles; data-independent latency.
- Quotient and sticky are identical in both builds.

Decomposition:
- basilisk package:
  - basilisk_divide_command_t and basilisk_divide_result_t.
  - Constant BASILISK_DIVIDE_QUOTIENT_WIDTH = 26.
- fpu_divide package:
  - Per-step function fpu_float_div_step(rem, div) returning {bit, next_rem}.
  - The RUN loop instantiates it BITS_PER_CYCLE times.
- Flow control: std_flow_stage on the output.
- No sub-module beyond that; the FSM is a single module.

Test Plan:
- 6.0/2.0 (mant 0xC00000/0x800000) -> quotient 0x3000000, sticky 0.
  - Latency with BITS_PER_CYCLE=1: 28 cycles + output stage.
  - With BASILISK_DIVIDE_EARLY_EXIT_EN: DONE after the 2nd RUN cycle.
- 1.0/3.0 (mant 0x800000/0xC00000) -> quotient 0x1555555, sticky 1; q[25]=0 passed through.
  - BITS_PER_CYCLE=2 gives the identical result in 13 RUN cycles.
- 1.0/0.0 with divide-by-zero flag -> bypass; result emitted 2 cycles after accept with quotient 0 and flags intact.
- Hold output ready=0 for 10 cycles in DONE -> payload stable, input ready stays 0.
  - Release -> exactly one transfer; next operand accepted the following cycle.
- Assert rst low mid-RUN (cycle 10) -> output valid 0 immediately.
  - After release, a new 6.0/2.0 completes correctly; no stale result is emitted.
- 500 random normal operand pairs with random output backpressure -> quotient/sticky match the reference model, with ordering preserved.
